serial_full_subtractor: RTL

- Bit-serial unsigned subtractor. Computes diff = a - b over WIDTH clocks, one bit per clock, LSB first.
- Datapath is one full-subtractor cell plus a registered borrow flip-flop, driven by a small FSM.
- Counterpart to the team's full-adder cell: the subtract direction of the same arithmetic path.
- Used where area matters more than latency; results are checked against a behavioural a-b model.

---
 rtl/serial_full_subtractor.sv | 105 ++++++++++
 1 files changed

// File: rtl/serial_full_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, one bit per clock, LSB first.
// One full-subtractor cell, a borrow flip-flop and a three-state sequencer.
module serial_full_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [WIDTH-1:0] sr_q;
    logic [CW-1:0]    cnt_q;
    logic             bf_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;

    logic             bit_d;
    logic             bf_d;
    logic [WIDTH-1:0] sr_d;
    logic             last_bit;

    // Full-subtractor cell on the current LSBs plus the shifted result.
    always_comb begin
        bit_d    = sa_q[0] ^ sb_q[0] ^ bf_q;
        bf_d     = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & bf_q);
        sr_d     = {bit_d, sr_q[WIDTH-1:1]};
        last_bit = (cnt_q == CW'(WIDTH - 1));
    end

    // Sequencer and datapath registers; all outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            sr_q     <= '0;
            cnt_q    <= '0;
            bf_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sa_q    <= a;
                        sb_q    <= b;
                        bf_q    <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    sa_q  <= sa_q >> 1;
                    sb_q  <= sb_q >> 1;
                    sr_q  <= sr_d;
                    bf_q  <= bf_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_bit) begin
                        diff_q   <= sr_d;
                        borrow_q <= bf_d;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= DONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule
